// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter_pkg
// Brief   : Shared owner/state encodings and constants for the memory bus arbiter.
// Revision: 1.0
// ============================================================================
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_INST = 2'd0,
        OWN_DRD  = 2'd1,
        OWN_DWR  = 2'd2
    } owner_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_DATA = 3'd4,
        WR_RESP = 3'd5
    } state_t;

    localparam logic [7:0] LEN_SINGLE = 8'd0;
    localparam logic [3:0] STRB_FULL  = 4'hF;

    // Bit positions of the one-hot grant vector
    localparam int GNT_INST = 0;
    localparam int GNT_DRD  = 1;
    localparam int GNT_DWR  = 2;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_prio.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_prio
// Brief   : Fixed-priority pick among icache, dcache-read and dcache-write requests.
// Revision: 1.0
// ============================================================================
module mem_arb_prio
    import mem_bus_arbiter_pkg::*;
#(
    parameter int WRITE_FIRST = 1
) (
    input  logic       i_req_inst,
    input  logic       i_req_drd,
    input  logic       i_req_dwr,
    output logic [2:0] o_gnt
);

    always_comb begin
        o_gnt = 3'b000;
        if (WRITE_FIRST != 0) begin
            if (i_req_dwr)       o_gnt[GNT_DWR]  = 1'b1;
            else if (i_req_drd)  o_gnt[GNT_DRD]  = 1'b1;
            else if (i_req_inst) o_gnt[GNT_INST] = 1'b1;
        end else begin
            if (i_req_drd)       o_gnt[GNT_DRD]  = 1'b1;
            else if (i_req_dwr)  o_gnt[GNT_DWR]  = 1'b1;
            else if (i_req_inst) o_gnt[GNT_INST] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter
// Brief   : Single-outstanding arbiter sharing one memory bus between icache
//           refill, dcache read and dcache write; drains flushed icache refills.
// Revision: 1.0
// ============================================================================
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int LINE_WORDS  = 8,
    parameter int WRITE_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inst_req_i,
    input  logic [31:0]              inst_addr_i,
    input  logic                     inst_flush_i,
    output logic                     inst_accept_o,
    output logic                     inst_rvalid_o,
    output logic                     inst_rlast_o,
    input  logic                     data_rd_req_i,
    input  logic [31:0]              data_rd_addr_i,
    input  logic                     data_rd_single_i,
    output logic                     data_rd_accept_o,
    output logic                     data_rvalid_o,
    output logic                     data_rlast_o,
    output logic [31:0]              rdata_o,
    input  logic                     data_wr_req_i,
    input  logic [31:0]              data_wr_addr_i,
    input  logic                     data_wr_single_i,
    input  logic [3:0]               data_wr_wstrb_i,
    input  logic [LINE_WORDS*32-1:0] data_wr_line_i,
    output logic                     data_wr_accept_o,
    output logic                     data_wr_done_o,
    output logic                     bus_req_o,
    output logic                     bus_we_o,
    output logic [31:0]              bus_addr_o,
    output logic [7:0]               bus_len_o,
    input  logic                     bus_gnt_i,
    output logic                     bus_wvalid_o,
    output logic [31:0]              bus_wdata_o,
    output logic [3:0]               bus_wstrb_o,
    output logic                     bus_wlast_o,
    input  logic                     bus_wready_i,
    input  logic                     bus_rvalid_i,
    input  logic [31:0]              bus_rdata_i,
    input  logic                     bus_rlast_i,
    input  logic                     bus_bvalid_i
);

    localparam int         IDX_W    = $clog2(LINE_WORDS);
    localparam logic [7:0] LEN_LINE = 8'(LINE_WORDS - 1);

    state_t           r_state;
    owner_t           r_owner;
    logic             r_drain;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [7:0]       r_len;
    logic [3:0]       r_strb;
    logic [31:0]      r_line [LINE_WORDS];
    logic [IDX_W-1:0] r_cnt;
    logic             r_wr_done;

    logic [2:0] w_gnt;
    logic       w_arb;
    logic       w_acc_inst;
    logic       w_acc_drd;
    logic       w_acc_dwr;
    logic       w_inst_beat;
    logic       w_inst_live;
    logic       w_wvalid;
    logic       w_wlast;

    mem_arb_prio #(
        .WRITE_FIRST (WRITE_FIRST)
    ) u_prio (
        .i_req_inst (inst_req_i),
        .i_req_drd  (data_rd_req_i),
        .i_req_dwr  (data_wr_req_i),
        .o_gnt      (w_gnt)
    );

    // Arbitration only happens out of IDLE and never while reset is held
    assign w_arb      = (r_state == IDLE) && !rst;
    assign w_acc_inst = w_arb && w_gnt[GNT_INST];
    assign w_acc_drd  = w_arb && w_gnt[GNT_DRD];
    assign w_acc_dwr  = w_arb && w_gnt[GNT_DWR];

    assign inst_accept_o    = w_acc_inst;
    assign data_rd_accept_o = w_acc_drd;
    assign data_wr_accept_o = w_acc_dwr;

    // A flush arriving on a beat hides that beat as well as all later ones
    assign w_inst_beat   = (r_state == RD_DATA) && (r_owner == OWN_INST) && bus_rvalid_i;
    assign w_inst_live   = w_inst_beat && !r_drain && !inst_flush_i;
    assign inst_rvalid_o = w_inst_live;
    assign inst_rlast_o  = w_inst_live && bus_rlast_i;

    assign data_rvalid_o = (r_state == RD_DATA) && (r_owner == OWN_DRD) && bus_rvalid_i;
    assign data_rlast_o  = data_rvalid_o && bus_rlast_i;
    assign rdata_o       = bus_rdata_i;

    assign w_wvalid = (r_state == WR_DATA);
    assign w_wlast  = w_wvalid && ({{(8-IDX_W){1'b0}}, r_cnt} == r_len);

    assign bus_req_o      = (r_state == RD_ADDR) || (r_state == WR_ADDR);
    assign bus_we_o       = r_we;
    assign bus_addr_o     = r_addr;
    assign bus_len_o      = r_len;
    assign bus_wvalid_o   = w_wvalid;
    assign bus_wdata_o    = w_wvalid ? r_line[r_cnt] : 32'd0;
    assign bus_wstrb_o    = w_wvalid ? r_strb : 4'd0;
    assign bus_wlast_o    = w_wlast;
    assign data_wr_done_o = r_wr_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner   <= OWN_INST;
            r_drain   <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_len     <= 8'd0;
            r_strb    <= 4'd0;
            r_cnt     <= '0;
            r_wr_done <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) r_line[i] <= 32'd0;
        end else begin
            r_wr_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_drain <= 1'b0;
                    r_cnt   <= '0;
                    if (w_acc_dwr) begin
                        r_owner <= OWN_DWR;
                        r_we    <= 1'b1;
                        r_addr  <= data_wr_addr_i;
                        r_len   <= data_wr_single_i ? LEN_SINGLE : LEN_LINE;
                        r_strb  <= data_wr_single_i ? data_wr_wstrb_i : STRB_FULL;
                        for (int i = 0; i < LINE_WORDS; i++)
                            r_line[i] <= data_wr_line_i[i*32 +: 32];
                        r_state <= WR_ADDR;
                    end else if (w_acc_drd) begin
                        r_owner <= OWN_DRD;
                        r_we    <= 1'b0;
                        r_addr  <= data_rd_addr_i;
                        r_len   <= data_rd_single_i ? LEN_SINGLE : LEN_LINE;
                        r_strb  <= STRB_FULL;
                        r_state <= RD_ADDR;
                    end else if (w_acc_inst) begin
                        r_owner <= OWN_INST;
                        r_we    <= 1'b0;
                        r_addr  <= inst_addr_i;
                        r_len   <= LEN_LINE;
                        r_strb  <= STRB_FULL;
                        r_drain <= inst_flush_i;
                        r_state <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (r_owner == OWN_INST && inst_flush_i) r_drain <= 1'b1;
                    if (bus_gnt_i) r_state <= RD_DATA;
                end
                RD_DATA: begin
                    if (r_owner == OWN_INST && inst_flush_i) r_drain <= 1'b1;
                    if (bus_rvalid_i && bus_rlast_i) begin
                        r_drain <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                WR_ADDR: begin
                    if (bus_gnt_i) r_state <= WR_DATA;
                end
                WR_DATA: begin
                    if (bus_wready_i) begin
                        if (w_wlast) r_state <= WR_RESP;
                        else         r_cnt   <= r_cnt + IDX_W'(1);
                    end
                end
                WR_RESP: begin
                    if (bus_bvalid_i) begin
                        r_wr_done <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Single-outstanding arbiter that shares the core's one memory bus between three requesters: icache line refill, dcache read (line refill or uncached word), and dcache write (line writeback or uncached word).
- Sits between the caches and the AXI bridge.
- Honours the pipeline front-end flush: an in-flight icache refill is drained silently instead of aborted.

Parameters:
- LINE_WORDS, 8, 32-bit words per cache line; power of two, 2..16.
- WRITE_FIRST, 1, when 1 a pending dcache write beats a dcache read in arbitration.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_req_i  in  1  icache refill request, held until accepted
- inst_addr_i  in  32  line-aligned refill address
- inst_flush_i  in  1  front-end flush (ctrl flush[1])
- inst_accept_o  out  1  one-cycle pulse: request latched
- inst_rvalid_o  out  1  refill beat valid
- inst_rlast_o  out  1  final refill beat
- data_rd_req_i  in  1  dcache read request, held until accepted
- data_rd_addr_i  in  32  read address
- data_rd_single_i  in  1  1 = one word, 0 = line
- data_rd_accept_o  out  1  one-cycle accept pulse
- data_rvalid_o  out  1  dcache read beat valid
- data_rlast_o  out  1  final dcache read beat
- rdata_o  out  32  beat data shared by both read returns (pass-through of bus_rdata_i)
- data_wr_req_i  in  1  dcache write request, held until accepted
- data_wr_addr_i  in  32  write address
- data_wr_single_i  in  1  1 = one word, 0 = line
- data_wr_wstrb_i  in  4  byte strobes, single writes only
- data_wr_line_i  in  LINE_WORDS*32  write payload; word 0 in bits [31:0]
- data_wr_accept_o  out  1  accept pulse; payload captured this cycle
- data_wr_done_o  out  1  one-cycle pulse on write response
- bus_req_o  out  1  address phase valid
- bus_we_o  out  1  1 = write transaction
- bus_addr_o  out  32  transaction address
- bus_len_o  out  8  beats minus one
- bus_gnt_i  in  1  address phase accepted
- bus_wvalid_o  out  1  write beat valid
- bus_wdata_o  out  32  write beat data
- bus_wstrb_o  out  4  write beat strobes
- bus_wlast_o  out  1  final write beat
- bus_wready_i  in  1  write beat accepted
- bus_rvalid_i  in  1  read beat valid
- bus_rdata_i  in  32  read beat data
- bus_rlast_i  in  1  final read beat
- bus_bvalid_i  in  1  write response (always accepted)

Behaviour:
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP.
- Reset: state IDLE, drain flag 0, all outputs 0. Reset mid-transaction abandons it; the bridge is reset on the same rst.
- Arbitration, IDLE only, fixed priority:
  - WRITE_FIRST=1: data_wr > data_rd > inst.
  - WRITE_FIRST=0: data_rd > data_wr > inst.
- Winner gets its accept pulse in the same cycle. Address, length, owner, strobes and payload are registered; next state is RD_ADDR or WR_ADDR. At most one accept per cycle.
- bus_len_o: single = 0, line = LINE_WORDS-1. Single reads use full strobes. Line writes drive wstrb 4'hF.
- RD_ADDR / WR_ADDR: bus_req_o=1 with registered fields until bus_gnt_i; then RD_DATA / WR_DATA next cycle. Fields stay stable while waiting.
- RD_DATA: each bus_rvalid_i beat raises the owner's rvalid, with rlast = bus_rlast_i, combinationally in the same cycle. A beat with bus_rlast_i returns the FSM to IDLE.
- WR_DATA:
  - Beat counter starts at 0 and drives word[counter] from the captured payload.
  - bus_wvalid_o=1; the counter increments on bus_wready_i.
  - bus_wlast_o=1 when counter == bus_len_o.
  - The wlast handshake moves the FSM to WR_RESP.
- WR_RESP: on bus_bvalid_i, pulse data_wr_done_o and return to IDLE.
- Flush, icache refill in flight (owner inst, state RD_ADDR or RD_DATA):
  - inst_flush_i sets the drain flag; the transaction still completes on the bus.
  - While drain=1, inst_rvalid_o and inst_rlast_o are forced 0.
  - Drain clears on return to IDLE.
- Flush in the same cycle as the inst accept: accept still pulses and drain is set.
- Flush with no inst transaction in flight: no effect.
- Flush never affects dcache transactions.
- A requester may assert its request again on the cycle after its accept or done; it is considered next time the FSM is in IDLE.
- Minimum transaction turnaround: one IDLE cycle between transactions.

Decomposition:
- Shared package/header: owner encoding (OWN_INST, OWN_DRD, OWN_DWR), FSM state constants, LEN_SINGLE = 8'd0.
- One natural sub-module: mem_arb_prio. Combinational fixed-priority pick of the three requests, parameterised by WRITE_FIRST, outputs a one-hot grant.

Test Plan:
- Line refill: inst_req with addr 0x1C000020, gnt after 2 cycles, 8 beats with rlast on the 8th -> bus_len_o=7, inst_accept_o once, 8 inst_rvalid_o pulses, inst_rlast_o only on beat 8, FSM back to IDLE.
- Arbitration: all three requests in the same cycle with WRITE_FIRST=1 -> order of service is dcache write, then dcache read, then icache; each accept one cycle only.
- Line writeback: payload words 0x0..0x7, wready deasserted on beats 3 and 5 -> wdata sequence 0..7 in order, wlast only on the 8th accepted beat, done pulse one cycle after bvalid is seen.
- Flush on beat 3 of an icache refill -> inst_rvalid_o=0 for beats 3..8, bus still consumes all 8 beats, next request is served normally.
- Uncached word: data_rd_single=1, addr 0xBFAF8000 -> bus_len_o=0, one data_rvalid_o with data_rlast_o=1. Data write single with wstrb 4'b0010 -> bus_wstrb_o=4'b0010, wlast=1.
- rst asserted mid-WR_DATA -> next cycle all outputs 0, state IDLE, pending requests re-arbitrated after rst drops.
